pipeline_arbiter: RTL and testbench
===================================

# pipeline_arbiter

Round-robin arbiter and sequencer that shares one fixed-depth data pipeline among `p_num_req` requesters. It owns the pipeline registers and carries a requester tag alongside each data word, so downstream logic can route results back. It stalls the whole pipeline under output backpressure and supports flush and a drain-to-halt sequence for clean reconfiguration. It sits between the request sources and any multi-stage datapath consumer.

## Interface
- `p_width`, 32, data width per word.
- `p_num_req`, 4, number of requesters (2..16).
- `p_stages`, 3, pipeline depth (1..8).
- `p_tag_w`, derived as max(1, $clog2(p_num_req)), tag width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_req_valid`  in  p_num_req  per-requester valid.
- `i_req_data`  in  p_num_req×p_width  per-requester data.
- `o_req_ready`  out  p_num_req  one-hot grant/accept, combinational.
- `o_valid`  out  1  last stage holds a valid word.
- `o_data`  out  p_width  last-stage data.
- `o_tag`  out  p_tag_w  requester index of the last-stage word.
- `i_out_ready`  in  1  downstream accepts `o_data`.
- `i_flush`  in  1  synchronous flush of all stages.
- `i_halt_req`  in  1  request drain and halt.
- `o_halted`  out  1  pipeline empty and no grants.

## Operation
- Stage k holds `{valid, tag, data}`. Stage 0 loads the granted request. Stage k loads stage k-1. `o_*` come from stage p_stages-1.
- Stall occurs when `o_valid && !i_out_ready`. During a stall, all stages hold and `o_req_ready` is all zeros.
- Grant:
  - The arbiter issues a grant only when all of the following hold: not stalled, state RUN, and `!i_flush`.
  - Search starts at the round-robin pointer `rr_ptr` and wraps modulo p_num_req. The first valid requester wins. `o_req_ready[winner]=1`.
  - Transfer occurs when `i_req_valid[i] && o_req_ready[i]`.
  - On a transfer, `rr_ptr` becomes winner+1, wrapping to 0 after p_num_req-1.
- With no transfer, stage 0 loads valid=0 unless stalled.
- Flush: `i_flush=1` clears all stage valids at the next edge. Flush overrides stall and overrides any accept. Data and tag contents are don't-care.
- State machine (RUN, DRAIN, HALT):
  - RUN → DRAIN when `i_halt_req=1`.
  - DRAIN: no grants; the pipeline advances normally. DRAIN → HALT when all stage valids are 0. DRAIN → RUN if `i_halt_req` drops before the pipeline empties.
  - HALT: `o_halted=1`, no grants. HALT → RUN when `i_halt_req=0`.
  - A flush in DRAIN empties the pipeline, so HALT follows one cycle later.

## Timing
- Reset values: all stage valids 0, `o_valid=0`, `o_data=0`, `o_tag=0`, `rr_ptr=0`, state RUN, `o_halted=0`, `o_req_ready` all 0 until a request is present.
- Latency is p_stages cycles from accept to `o_valid`, plus one cycle per stall cycle.
- Throughput is one word per cycle with no stall.
- `o_req_ready` depends combinationally on `i_req_valid`, `i_out_ready`, `i_flush`, state and `rr_ptr`. No combinational path exists from `i_req_data`.
- `o_halted` is registered; it asserts the cycle after the last valid leaves the pipeline.
- Reset asserted mid-operation clears everything asynchronously. In-flight words are lost.

## Configuration
- `PIPELINE_ARB_STALL_CNT_EN` defined:
  - Adds output `o_stall_cnt` (16 bits), a count of stall cycles.
  - The counter saturates at 0xFFFF, is reset to 0, and is cleared by `i_flush`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Single requester, no backpressure.** Req 2 presents 0xA5A5A5A5 at cycle 0 → `o_valid=1`, `o_data=0xA5A5A5A5`, `o_tag=2` at cycle 3; `o_valid=0` at cycle 4.
- **All four requesters valid continuously.** Grants follow 0,1,2,3,0,…; `o_tag` sequence is 0,1,2,3 starting at cycle 3.
- **Stall.** `i_out_ready=0` for 5 cycles with a full pipeline → `o_data` constant, `o_req_ready=0`; the stream resumes in order with no loss or duplication. With the macro defined, `o_stall_cnt=5`.
- **Flush with simultaneous request.** `i_flush=1` with req 1 valid and a full pipeline → no accept; all valids 0 next cycle; `rr_ptr` unchanged.
- **Drain sequence.** Raise `i_halt_req` with 3 words in flight → exactly those 3 words exit; `o_halted=1` one cycle after the last; drop `i_halt_req` → grants resume the next cycle.
- **Reset mid-stream.** Assert `i_rst` while `o_valid=1` → `o_valid`, `o_tag` and `o_data` are 0 immediately; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/pipeline_arbiter.sv
// pipeline_arbiter: round-robin arbiter feeding a fixed-depth pipeline that
// carries a requester tag with every word. Supports output backpressure
// (whole-pipe stall), synchronous flush and a drain-to-halt handshake.
// Optional feature macro: PIPELINE_ARB_STALL_CNT_EN adds o_stall_cnt, a
// saturating 16-bit count of stall cycles (cleared by reset and i_flush).
module pipeline_arbiter #(
  parameter int unsigned p_width   = 32,
  parameter int unsigned p_num_req = 4,
  parameter int unsigned p_stages  = 3,
  localparam int unsigned p_tag_w  = (p_num_req > 1) ? $clog2(p_num_req) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [p_num_req-1:0]              i_req_valid,
  input  logic [p_num_req-1:0][p_width-1:0] i_req_data,
  output logic [p_num_req-1:0]              o_req_ready,
  output logic                              o_valid,
  output logic [p_width-1:0]                o_data,
  output logic [p_tag_w-1:0]                o_tag,
  input  logic                              i_out_ready,
  input  logic                              i_flush,
  input  logic                              i_halt_req,
`ifdef PIPELINE_ARB_STALL_CNT_EN
  output logic [15:0]                       o_stall_cnt,
`endif
  output logic                              o_halted
);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e                             state_q, state_d;
  logic [p_tag_w-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [p_stages-1:0]                valid_q, valid_d;
  logic [p_stages-1:0][p_tag_w-1:0]   tag_q, tag_d;
  logic [p_stages-1:0][p_width-1:0]   data_q, data_d;

  logic               stall;
  logic               grant_en;
  logic               xfer;
  logic [p_tag_w-1:0] win;
  logic [p_num_req-1:0] grant;

  assign stall    = valid_q[p_stages-1] && !i_out_ready;
  assign grant_en = !stall && (state_q == StRun) && !i_flush;

  // Round-robin search starting at rr_ptr_q; first valid requester wins.
  always_comb begin
    int unsigned cand;
    grant = '0;
    win   = '0;
    xfer  = 1'b0;
    cand  = 0;
    if (grant_en) begin
      for (int unsigned i = 0; i < p_num_req; i++) begin
        cand = 32'(rr_ptr_q) + i;
        if (cand >= p_num_req) cand = cand - p_num_req;
        if (!xfer && i_req_valid[p_tag_w'(cand)]) begin
          xfer                 = 1'b1;
          win                  = p_tag_w'(cand);
          grant[p_tag_w'(cand)] = 1'b1;
        end
      end
    end
  end

  assign o_req_ready = grant;

  // Pointer moves past the winner only when a word is actually accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (win == p_tag_w'(p_num_req - 1)) ? '0 : win + 1'b1;
    end
  end

  // Pipeline advance: flush beats stall, stall freezes every stage.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (i_flush) begin
      valid_d = '0;
    end else if (!stall) begin
      for (int k = p_stages - 1; k > 0; k--) begin
        valid_d[k] = valid_q[k-1];
        tag_d[k]   = tag_q[k-1];
        data_d[k]  = data_q[k-1];
      end
      valid_d[0] = xfer;
      if (xfer) begin
        tag_d[0]  = win;
        data_d[0] = i_req_data[win];
      end
    end
  end

  // Drain/halt sequencing; dropping the request always returns to RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (i_halt_req) state_d = StDrain;
      StDrain: begin
        if (!i_halt_req)          state_d = StRun;
        else if (valid_d == '0)   state_d = StHalt;
      end
      StHalt:  if (!i_halt_req) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // State, pointer and pipeline registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StRun;
      rr_ptr_q <= '0;
      valid_q  <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
    end
  end

  assign o_valid  = valid_q[p_stages-1];
  assign o_data   = data_q[p_stages-1];
  assign o_tag    = tag_q[p_stages-1];
  assign o_halted = (state_q == StHalt);

`ifdef PIPELINE_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating stall counter, cleared by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_flush) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Testbench for pipeline_arbiter: directed steps plus a randomized phase,
// every cycle compared against a queue-based reference model.
module tb_pipeline_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned S  = 3;
  localparam int unsigned TW = 2;

  logic                    i_clk = 1'b0;
  logic                    i_rst;
  logic [N-1:0]            i_req_valid;
  logic [N-1:0][W-1:0]     i_req_data;
  logic [N-1:0]            o_req_ready;
  logic                    o_valid;
  logic [W-1:0]            o_data;
  logic [TW-1:0]           o_tag;
  logic                    i_out_ready;
  logic                    i_flush;
  logic                    i_halt_req;
  logic                    o_halted;
`ifdef PIPELINE_ARB_STALL_CNT_EN
  logic [15:0]             o_stall_cnt;
`endif

  always #5 i_clk = ~i_clk;

  pipeline_arbiter #(
    .p_width  (W),
    .p_num_req(N),
    .p_stages (S)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req_valid(i_req_valid),
    .i_req_data (i_req_data),
    .o_req_ready(o_req_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_tag      (o_tag),
    .i_out_ready(i_out_ready),
    .i_flush    (i_flush),
    .i_halt_req (i_halt_req),
`ifdef PIPELINE_ARB_STALL_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_halted   (o_halted)
  );

  typedef struct {
    bit          v;
    int unsigned tag;
    logic [W-1:0] data;
  } ent_t;

  // Reference model: pipe[0] is the entry stage, pipe[S-1] the output stage.
  ent_t        pipe[$];
  int unsigned m_rr;
  int          m_state;  // 0 run, 1 drain, 2 halt
  int unsigned m_stall;
  int          n_pass;
  int          n_total;

  function automatic void model_reset();
    pipe.delete();
    for (int k = 0; k < S; k++) pipe.push_back('{v: 1'b0, tag: 0, data: '0});
    m_rr    = 0;
    m_state = 0;
    m_stall = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Expected grant for the current inputs, from the arbitration rules.
  task automatic predict(output logic [N-1:0] g, output int unsigned win, output bit st);
    bit found;
    g     = '0;
    win   = 0;
    found = 1'b0;
    st    = pipe[S-1].v && !i_out_ready;
    if (!st && m_state == 0 && !i_flush) begin
      for (int unsigned i = 0; i < N; i++) begin
        int unsigned idx;
        idx = (m_rr + i) % N;
        if (!found && i_req_valid[idx]) begin
          found  = 1'b1;
          win    = idx;
          g[idx] = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic step();
    logic [N-1:0] g;
    int unsigned  win;
    bit           st;
    bit           any;
    #1;
    predict(g, win, st);
    chk("req_ready", 32'(o_req_ready), 32'(g));
    chk("valid", 32'(o_valid), 32'(pipe[S-1].v));
    if (pipe[S-1].v) begin
      chk("tag", 32'(o_tag), pipe[S-1].tag);
      chk("data", o_data, pipe[S-1].data);
    end
    chk("halted", 32'(o_halted), 32'(m_state == 2));
`ifdef PIPELINE_ARB_STALL_CNT_EN
    chk("stall_cnt", 32'(o_stall_cnt), m_stall);
`endif
    @(posedge i_clk);
    if (i_flush) m_stall = 0;
    else if (st && m_stall < 65535) m_stall++;
    if (i_flush) begin
      foreach (pipe[k]) pipe[k].v = 1'b0;
    end else if (!st) begin
      void'(pipe.pop_back());
      if (g != '0) pipe.push_front('{v: 1'b1, tag: win, data: i_req_data[win]});
      else         pipe.push_front('{v: 1'b0, tag: 0, data: '0});
    end
    if (g != '0) m_rr = (win + 1) % N;
    any = 1'b0;
    foreach (pipe[k]) any |= pipe[k].v;
    case (m_state)
      0: if (i_halt_req) m_state = 1;
      1: begin
        if (!i_halt_req) m_state = 0;
        else if (!any)   m_state = 2;
      end
      default: if (!i_halt_req) m_state = 0;
    endcase
    @(negedge i_clk);
  endtask

  task automatic rand_data();
    for (int r = 0; r < N; r++) i_req_data[r] = $urandom;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    i_rst       = 1'b1;
    i_req_valid = '0;
    i_req_data  = '0;
    i_out_ready = 1'b1;
    i_flush     = 1'b0;
    i_halt_req  = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_tag", 32'(o_tag), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Single requester: word appears on the output three cycles later.
    i_req_valid   = 4'b0100;
    i_req_data[2] = 32'hA5A5A5A5;
    step();
    i_req_valid = '0;
    repeat (4) step();

    // All requesters continuously valid.
    i_req_valid = '1;
    repeat (8) begin rand_data(); step(); end

    // Five stall cycles with a full pipeline, then drain out.
    i_out_ready = 1'b0;
    repeat (5) step();
    i_out_ready = 1'b1;
    i_req_valid = '0;
    repeat (4) step();

    // Flush with a pending request and a full pipeline.
    i_req_valid = '1;
    repeat (3) begin rand_data(); step(); end
    i_req_valid = 4'b0010;
    i_flush     = 1'b1;
    step();
    i_flush     = 1'b0;
    i_req_valid = '1;
    repeat (3) begin rand_data(); step(); end

    // Drain with three words in flight, hold halt, then release.
    i_req_valid = '0;
    i_halt_req  = 1'b1;
    repeat (6) step();
    i_req_valid = '1;
    repeat (2) step();
    i_halt_req = 1'b0;
    repeat (4) begin rand_data(); step(); end

    // Randomized traffic with backpressure, flushes and halt toggling.
    repeat (400) begin
      i_req_valid = N'($urandom);
      rand_data();
      i_out_ready = ($urandom_range(0, 9) < 7);
      i_flush     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) i_halt_req = ~i_halt_req;
      step();
    end
    i_flush     = 1'b0;
    i_halt_req  = 1'b0;
    i_out_ready = 1'b1;

    // Asynchronous reset while a word is on the output.
    i_req_valid = '1;
    repeat (5) begin rand_data(); step(); end
    #1;
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    #1;
    i_rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_tag", 32'(o_tag), 32'd0);
    chk("async_rst_data", o_data, 32'd0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (5) begin rand_data(); step(); end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
